pll_reset_sequencer: RTL

Sequencer for the clock-generation PLL and the reset trees of the clock domains it feeds (CPU, memory, peripheral). It holds the PLL in reset at power-up, waits for a stable lock, then releases each domain's reset in a fixed order. It detects lock loss, retries a bounded number of times, and offers a four-phase soft-reset handshake to software and debug logic. It sits beside the PLL in the top level and is clocked from the free-running board reference clock, not from any PLL output.

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        SOFT_HOLD,
        FAULT
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Largest of four cycle counts; sizes the shared phase counter.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser; both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Capture the asynchronous level, then re-register it to let metastability settle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and domain-reset release sequencer with lock-loss recovery,
// bounded lock retries and a four-phase soft-reset handshake.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// PLL_RST   | PLL held in reset for PLL_RESET_CYCLES, all domains in reset
// WAIT_LOCK | PLL running, waiting for lock; times out after LOCK_TIMEOUT
// STABLE    | counting consecutive locked cycles up to LOCK_STABLE_CYCLES
// RELEASE   | releasing domain resets one by one, RELEASE_GAP apart
// RUN       | all domains out of reset, all_ready_o high
// SOFT_HOLD | soft reset: domains held in reset for RELEASE_GAP, PLL untouched
// FAULT     | retry limit hit; everything held in reset until rst_i
//
// NUM_DOMAINS must be at least 2: the first release happens on RELEASE entry
// and the remaining bits are released from inside RELEASE.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 3,
    parameter int PLL_RESET_CYCLES   = 8,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP        = 16,
    parameter int RETRY_LIMIT        = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pll_locked_i,
    output logic                   pll_areset_o,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic                   all_ready_o,
    input  logic                   soft_rst_req_i,
    output logic                   soft_rst_ack_o,
    output logic                   fault_o,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
);

    localparam int CNT_MAX = max_of4(PLL_RESET_CYCLES, LOCK_TIMEOUT,
                                     LOCK_STABLE_CYCLES, RELEASE_GAP);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int RTY_W   = $clog2(RETRY_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_LIMIT - 1);

    localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = '1;
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = DOM_ALL << 1;

    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] dom_idx;
    logic [RTY_W-1:0] retry;
    logic             soft_active;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (locked_s)
    );

    // Sequencer FSM with registered outputs; the shared counter restarts on every state entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= PLL_RST;
            cnt             <= '0;
            dom_idx         <= '0;
            retry           <= '0;
            soft_active     <= 1'b0;
            pll_areset_o    <= 1'b1;
            dom_rst_o       <= DOM_ALL;
            all_ready_o     <= 1'b0;
            soft_rst_ack_o  <= 1'b0;
            fault_o         <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            // Four-phase return: ack drops one cycle after the request drops
            if (soft_rst_ack_o && !soft_rst_req_i) begin
                soft_rst_ack_o <= 1'b0;
            end

            // Lock loss with domains (partly) released wins over everything else
            if ((state == RELEASE || state == RUN) && !locked_s) begin
                state        <= PLL_RST;
                cnt          <= '0;
                soft_active  <= 1'b0;
                pll_areset_o <= 1'b1;
                dom_rst_o    <= DOM_ALL;
                all_ready_o  <= 1'b0;
                if (lock_loss_cnt_o != LOSS_MAX) begin
                    lock_loss_cnt_o <= lock_loss_cnt_o + LOSS_ONE;
                end
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == PRST_LAST) begin
                            state        <= WAIT_LOCK;
                            cnt          <= '0;
                            pll_areset_o <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TMO_LAST) begin
                            cnt          <= '0;
                            retry        <= retry + RTY_ONE;
                            pll_areset_o <= 1'b1;
                            if (retry == RTY_LAST) begin
                                state   <= FAULT;
                                fault_o <= 1'b1;
                            end else begin
                                state <= PLL_RST;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    STABLE: begin
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state     <= RELEASE;
                            cnt       <= '0;
                            dom_idx   <= IDX_ONE;
                            dom_rst_o <= DOM_FIRST;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt                <= '0;
                            dom_rst_o[dom_idx] <= 1'b0;
                            if (dom_idx == IDX_LAST) begin
                                state          <= RUN;
                                all_ready_o    <= 1'b1;
                                retry          <= '0;
                                soft_active    <= 1'b0;
                                soft_rst_ack_o <= soft_active & soft_rst_req_i;
                            end else begin
                                dom_idx <= dom_idx + IDX_ONE;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    RUN: begin
                        if (soft_rst_req_i && !soft_rst_ack_o) begin
                            state       <= SOFT_HOLD;
                            cnt         <= '0;
                            soft_active <= 1'b1;
                            dom_rst_o   <= DOM_ALL;
                            all_ready_o <= 1'b0;
                        end
                    end

                    SOFT_HOLD: begin
                        if (cnt == GAP_LAST) begin
                            state     <= RELEASE;
                            cnt       <= '0;
                            dom_idx   <= IDX_ONE;
                            dom_rst_o <= DOM_FIRST;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    FAULT: begin
                        fault_o      <= 1'b1;
                        pll_areset_o <= 1'b1;
                        dom_rst_o    <= DOM_ALL;
                        all_ready_o  <= 1'b0;
                    end

                    default: begin
                        state        <= PLL_RST;
                        cnt          <= '0;
                        pll_areset_o <= 1'b1;
                        dom_rst_o    <= DOM_ALL;
                        all_ready_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
